// File: rtl/subtractor_32_serial_pkg.sv
// Package sub_pkg: shared defaults and FSM encoding for the digit-serial
// subtractor.
//   WIDTH_DEF / DIGIT_W_DEF : default operand width and digit width
//   N_DEF / CNT_W_DEF       : default digit count and digit-counter width
//   state_t                 : IDLE / RUN / DONE
package sub_pkg;
  localparam int WIDTH_DEF   = 32;
  localparam int DIGIT_W_DEF = 4;
  localparam int N_DEF       = WIDTH_DEF / DIGIT_W_DEF;
  localparam int CNT_W_DEF   = $clog2(N_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/subtractor_32_serial_full_subtractor.sv
// full_subtractor: 1-bit subtract cell, {b_out, d} = a - b - b_in.
//   a, b, b_in : minuend bit, subtrahend bit, borrow in
//   d, b_out   : difference bit, borrow out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);
  assign d     = a ^ b ^ b_in;
  // Borrow when a=0,b=1, or when a==b and a borrow arrives from below.
  assign b_out = (~a & b) | (~(a ^ b) & b_in);
endmodule

// File: rtl/subtractor_32_serial.sv
// subtractor_32_serial: digit-serial D = A - B - BorrowIn, DIGIT_W bits per
// clock, LSB digit first, borrow carried between digits in a flop.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   start                : request, accepted when not busy (IDLE or DONE)
//   A, B, BorrowIn       : operands, latched on the accepting cycle
//   busy                 : high during the N RUN cycles
//   done                 : one-cycle pulse, D/BorrowOut valid from then on
//   D, BorrowOut         : difference mod 2^WIDTH, borrow out (A < B+BorrowIn)
//   Zero, Negative, Overflow : result flags, present only when the macro
//                          SUB_FLAGS_EN is defined
module subtractor_32_serial
  import sub_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DIGIT_W = DIGIT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BorrowIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
`ifdef SUB_FLAGS_EN
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow,
`endif
  output logic             BorrowOut
);
  localparam int N     = WIDTH / DIGIT_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  // Partial-result register holds the N-1 digits produced before the last.
  localparam int RES_W = (N > 1) ? WIDTH - DIGIT_W : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit
    $error("subtractor_32_serial: DIGIT_W must divide WIDTH");
  end

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_borrow;
  logic [RES_W-1:0]   r_res;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_d;
  logic               r_bout;
`ifdef SUB_FLAGS_EN
  logic               r_a_msb;
  logic               r_b_msb;
  logic               r_zero;
  logic               r_neg;
  logic               r_ovf;
`endif

  logic [DIGIT_W-1:0] w_d;
  logic [DIGIT_W:0]   w_bchain;
  logic [WIDTH-1:0]   w_full;

  // Ripple chain for the current digit; operand registers shift right so the
  // active digit always sits in the low DIGIT_W bits.
  assign w_bchain[0] = r_borrow;
  for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_fs
    full_subtractor u_fs (
      .a    (r_a[gi]),
      .b    (r_b[gi]),
      .b_in (w_bchain[gi]),
      .d    (w_d[gi]),
      .b_out(w_bchain[gi+1])
    );
  end

  // New digit enters at the top; on the last digit this is the full result.
  if (N > 1) begin : g_multi
    assign w_full = {w_d, r_res};
  end else begin : g_single
    assign w_full = w_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_res    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_d      <= '0;
      r_bout   <= 1'b0;
`ifdef SUB_FLAGS_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= A;
            r_b      <= B;
            // Preloading the borrow flop makes digit 0 use BorrowIn.
            r_borrow <= BorrowIn;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
`ifdef SUB_FLAGS_EN
            r_a_msb  <= A[WIDTH-1];
            r_b_msb  <= B[WIDTH-1];
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> DIGIT_W;
          r_b      <= r_b >> DIGIT_W;
          r_borrow <= w_bchain[DIGIT_W];
          r_res    <= w_full[WIDTH-1 -: RES_W];
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
            r_d     <= w_full;
            r_bout  <= w_bchain[DIGIT_W];
`ifdef SUB_FLAGS_EN
            r_zero  <= (w_full == '0);
            r_neg   <= w_full[WIDTH-1];
            r_ovf   <= (r_a_msb != r_b_msb) && (w_full[WIDTH-1] != r_a_msb);
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign D         = r_d;
  assign BorrowOut = r_bout;
`ifdef SUB_FLAGS_EN
  assign Zero      = r_zero;
  assign Negative  = r_neg;
  assign Overflow  = r_ovf;
`endif
endmodule

// File: tb/tb_subtractor_32_serial.sv
// Bench for subtractor_32_serial: directed vectors, a cycle-level reference
// model of the start/done protocol, and literal spot checks.
module tb_subtractor_32_serial;
  localparam int W = 32;
  localparam int N = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          BorrowIn;
  logic          busy;
  logic          done;
  logic [W-1:0]  D;
  logic          BorrowOut;
`ifdef SUB_FLAGS_EN
  logic          Zero, Negative, Overflow;
`endif

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  subtractor_32_serial dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .BorrowIn (BorrowIn),
    .busy     (busy),
    .done     (done),
    .D        (D),
`ifdef SUB_FLAGS_EN
    .Zero     (Zero),
    .Negative (Negative),
    .Overflow (Overflow),
`endif
    .BorrowOut(BorrowOut)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is a countdown of N busy cycles after the
  // accepting edge; its result is plain 33-bit arithmetic on the latched inputs.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_d = '0, p_d = '0;
  logic         m_bo = 1'b0, p_bo = 1'b0;
  logic         m_z = 1'b0, m_n = 1'b0, m_v = 1'b0, p_v = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0; m_done <= 1'b0; m_d <= '0; m_bo <= 1'b0;
      m_z <= 1'b0; m_n <= 1'b0; m_v <= 1'b0;
    end else begin
      m_done <= (m_left == 1);
      if (m_left == 1) begin
        m_d <= p_d; m_bo <= p_bo;
        m_z <= (p_d == 0); m_n <= p_d[W-1]; m_v <= p_v;
      end
      if (start && m_left == 0) begin
        {p_bo, p_d} <= {1'b0, A} - {1'b0, B} - {{W{1'b0}}, BorrowIn};
        p_v    <= (A[W-1] != B[W-1]) && ((A - B - {{(W-1){1'b0}}, BorrowIn}) >> (W-1)) != {{(W-1){1'b0}}, A[W-1]};
        m_left <= N;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {63'b0, busy}, {63'b0, (m_left != 0)});
      chk("done", {63'b0, done}, {63'b0, m_done});
      chk("D", {32'b0, D}, {32'b0, m_d});
      chk("BorrowOut", {63'b0, BorrowOut}, {63'b0, m_bo});
`ifdef SUB_FLAGS_EN
      chk("Zero", {63'b0, Zero}, {63'b0, m_z});
      chk("Negative", {63'b0, Negative}, {63'b0, m_n});
      chk("Overflow", {63'b0, Overflow}, {63'b0, m_v});
`endif
      if (done) done_cnt++;
    end
  end

  // Launch one operation and return the number of negedges from the start
  // request to the observed done pulse (bounded).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                       output int lat);
    @(negedge clk);
    A = a; B = b; BorrowIn = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; BorrowIn = 1'($urandom);
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int lat;
  int lat2;

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; BorrowIn = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_D", {32'b0, D}, 64'd0);
    chk("rst_bo", {63'b0, BorrowOut}, 64'd0);
`ifdef SUB_FLAGS_EN
    chk("rst_flags", {61'b0, Zero, Negative, Overflow}, 64'd0);
`endif
    reset = 1'b0;

    // 10 - 3
    do_op(32'd10, 32'd3, 1'b0, lat);
    $display("op 10-3-0: lat=%0d D=%h bo=%b", lat, D, BorrowOut);
    chk("lat_10_3", lat, 64'd9);
    chk("D_10_3", {32'b0, D}, 64'd7);
    chk("bo_10_3", {63'b0, BorrowOut}, 64'd0);

    // 0 - 1 wraps
    do_op(32'd0, 32'd1, 1'b0, lat);
    $display("op 0-1-0: lat=%0d D=%h bo=%b", lat, D, BorrowOut);
    chk("D_0_1", {32'b0, D}, 64'hFFFF_FFFF);
    chk("bo_0_1", {63'b0, BorrowOut}, 64'd1);
`ifdef SUB_FLAGS_EN
    chk("neg_0_1", {63'b0, Negative}, 64'd1);
    chk("ovf_0_1", {63'b0, Overflow}, 64'd0);
`endif

    // Signed overflow boundary
    do_op(32'h8000_0000, 32'd1, 1'b0, lat);
    $display("op 80000000-1-0: lat=%0d D=%h bo=%b", lat, D, BorrowOut);
    chk("D_min_1", {32'b0, D}, 64'h7FFF_FFFF);
    chk("bo_min_1", {63'b0, BorrowOut}, 64'd0);
`ifdef SUB_FLAGS_EN
    chk("ovf_min_1", {63'b0, Overflow}, 64'd1);
`endif

    // Equal operands
    do_op(32'd5, 32'd5, 1'b0, lat);
    $display("op 5-5-0: lat=%0d D=%h bo=%b", lat, D, BorrowOut);
    chk("D_5_5", {32'b0, D}, 64'd0);
    chk("bo_5_5", {63'b0, BorrowOut}, 64'd0);
`ifdef SUB_FLAGS_EN
    chk("zero_5_5", {63'b0, Zero}, 64'd1);
`endif

    // Borrow-in propagating through every digit: 0 - 0 - 1
    do_op(32'd0, 32'd0, 1'b1, lat);
    $display("op 0-0-1: lat=%0d D=%h bo=%b", lat, D, BorrowOut);
    chk("D_0_0_1", {32'b0, D}, 64'hFFFF_FFFF);
    chk("bo_0_0_1", {63'b0, BorrowOut}, 64'd1);

    // Mixed digits with borrow-in
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, lat);
    $display("op 12345678-0FEDCBA9-1: lat=%0d D=%h bo=%b", lat, D, BorrowOut);
    chk("D_mix", {32'b0, D}, 64'h0246_8ACE);

    // start during RUN is ignored
    @(negedge clk);
    A = 32'd100; B = 32'd1; BorrowIn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 30) begin
      if (lat == 4) begin A = 32'd0; B = 32'd5; BorrowIn = 1'b1; start = 1'b1; end
      if (lat == 5) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    $display("op 100-1-0 with mid-run start: lat=%0d D=%h bo=%b", lat, D, BorrowOut);
    chk("lat_ign", lat, 64'd9);
    chk("D_ign", {32'b0, D}, 64'd99);
    repeat (3) @(negedge clk);
    chk("idle_after_ign", {63'b0, busy}, 64'd0);

    // reset in RUN cycle 4 aborts
    done_cnt = 0;
    @(negedge clk);
    A = 32'd50; B = 32'd8; BorrowIn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    $display("op 50-8-0 aborted by reset: done_cnt=%0d D=%h bo=%b", done_cnt, D, BorrowOut);
    chk("abort_no_done", done_cnt, 64'd0);
    chk("abort_D", {32'b0, D}, 64'd0);
    chk("abort_busy", {63'b0, busy}, 64'd0);

    // back-to-back: start held through DONE
    @(negedge clk);
    A = 32'd10; B = 32'd3; BorrowIn = 1'b0; start = 1'b1;
    @(negedge clk);
    A = 32'd7; B = 32'd2; BorrowIn = 1'b1;
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    chk("b2b_first_D", {32'b0, D}, 64'd7);
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    chk("b2b_busy_rise", {63'b0, busy}, 64'd1);
    chk("b2b_done_pulse", {63'b0, done}, 64'd0);
    lat2 = 1;
    while (!done && lat2 < 30) begin
      @(negedge clk);
      lat2++;
    end
    $display("op 7-2-1 back-to-back: lat=%0d D=%h bo=%b", lat2, D, BorrowOut);
    chk("b2b_lat", lat2, 64'd9);
    chk("b2b_D", {32'b0, D}, 64'd4);
    chk("b2b_bo", {63'b0, BorrowOut}, 64'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
